// File: rtl/nrs_qpsk_reader_rx.sv
// -----------------------------------------------------------------------------
// nrs_qpsk_reader_rx
//
// Consumer side of the NRS bit buffer. When the generator flags a batch
// (nrs_ready), the block reads the Gold-sequence bits two at a time.
// Each pair is mapped to one QPSK reference symbol:
//   bit 0 -> +QPSK_MAG, bit 1 -> -QPSK_MAG  (QPSK_MAG = 1/sqrt(2) in Q1.15)
// The first bit of a pair drives I and the second drives Q.
// Symbols go to the channel estimator over valid/ready. After the last
// symbol of the batch is accepted, est_ack pulses for one clock to release
// the batch back to the generator.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active-low
//   nrs_ready  batch available (generator ready flag), sampled in IDLE only
//   rd_en      buffer read strobe (decoded from state)
//   rd_addr    buffer read address (registered read pointer)
//   rd_data    buffer bit, valid one clock after rd_en
//   sym_valid  symbol valid to the estimator
//   sym_ready  estimator accepts the symbol
//   sym_i      signed I component
//   sym_q      signed Q component
//   sym_last   final symbol of a batch, qualified by sym_valid
//   est_ack    one-clock pulse: batch consumed
// -----------------------------------------------------------------------------
module nrs_qpsk_reader_rx #(
  parameter int WIDTH_REG      = 16,
  parameter int LINES          = $clog2(WIDTH_REG),
  parameter int SYMS_PER_BATCH = 2,
  parameter int IQ_WIDTH       = 16,
  parameter int QPSK_MAG       = 23170
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       nrs_ready,
  output logic                       rd_en,
  output logic [LINES-1:0]           rd_addr,
  input  logic                       rd_data,
  output logic                       sym_valid,
  input  logic                       sym_ready,
  output logic signed [IQ_WIDTH-1:0] sym_i,
  output logic signed [IQ_WIDTH-1:0] sym_q,
  output logic                       sym_last,
  output logic                       est_ack
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ_I  = 3'd1;
  localparam logic [2:0] S_READ_Q  = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_PRESENT = 3'd4;
  localparam logic [2:0] S_ACK     = 3'd5;

  localparam int CNT_W = (SYMS_PER_BATCH > 1) ? $clog2(SYMS_PER_BATCH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYMS_PER_BATCH - 1);
  localparam logic [LINES-1:0] PTR_MAX  = LINES'(WIDTH_REG - 1);

  localparam logic signed [IQ_WIDTH-1:0] MAG_POS = IQ_WIDTH'(QPSK_MAG);
  localparam logic signed [IQ_WIDTH-1:0] MAG_NEG = -MAG_POS;

  logic [2:0]                 state_reg;
  logic [2:0]                 state_next;
  logic [LINES-1:0]           ptr_reg;
  logic [LINES-1:0]           ptr_inc;
  logic [CNT_W-1:0]           cnt_reg;
  logic                       i_bit_reg;
  logic                       sym_valid_reg;
  logic                       sym_last_reg;
  logic signed [IQ_WIDTH-1:0] sym_i_reg;
  logic signed [IQ_WIDTH-1:0] sym_q_reg;

  // Explicit wrap so a non-power-of-two buffer depth still stays in
  // lockstep with the generator's write pointer.
  assign ptr_inc = (ptr_reg == PTR_MAX) ? '0 : ptr_reg + LINES'(1);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (nrs_ready) state_next = S_READ_I;
      S_READ_I:  state_next = S_READ_Q;
      S_READ_Q:  state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_PRESENT;
      S_PRESENT: begin
        // sym_valid is always high in PRESENT, so sym_ready alone completes
        // the handshake.
        if (sym_ready) state_next = sym_last_reg ? S_ACK : S_READ_I;
      end
      S_ACK:     state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      ptr_reg       <= '0;
      cnt_reg       <= '0;
      i_bit_reg     <= 1'b0;
      sym_valid_reg <= 1'b0;
      sym_last_reg  <= 1'b0;
      sym_i_reg     <= '0;
      sym_q_reg     <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_READ_I: begin
          ptr_reg <= ptr_inc;
        end
        S_READ_Q: begin
          ptr_reg   <= ptr_inc;
          // Data for the READ_I access arrives now.
          i_bit_reg <= rd_data;
        end
        S_CAPTURE: begin
          // rd_data now carries the Q bit from the READ_Q access.
          sym_i_reg     <= i_bit_reg ? MAG_NEG : MAG_POS;
          sym_q_reg     <= rd_data   ? MAG_NEG : MAG_POS;
          sym_valid_reg <= 1'b1;
          sym_last_reg  <= (cnt_reg == LAST_CNT);
        end
        S_PRESENT: begin
          if (sym_ready) begin
            sym_valid_reg <= 1'b0;
            sym_last_reg  <= 1'b0;
            if (sym_last_reg) cnt_reg <= '0;
            else              cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_en     = (state_reg == S_READ_I) || (state_reg == S_READ_Q);
  assign est_ack   = (state_reg == S_ACK);
  assign rd_addr   = ptr_reg;
  assign sym_valid = sym_valid_reg;
  assign sym_last  = sym_last_reg;
  assign sym_i     = sym_i_reg;
  assign sym_q     = sym_q_reg;

endmodule
